// File: rtl/cnn_pkg.sv
// Shared constants for the conv-unit result path: default word width, fp16 sign
// position and the collector state encoding.
package cnn_pkg;

  localparam int unsigned CNN_DATA_WIDTH = 16;
  localparam int unsigned FP16_SIGN      = 15;

  // Collector states: gathering words, or holding a complete map.
  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } state_e;

endpackage

// File: rtl/relu16.sv
// Fused ReLU for one result word: a word with its sign bit set is replaced by zero.
module relu16
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CNN_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] i_word,
  output logic [DATA_WIDTH-1:0] o_word_c
);

  // Negative values (MSB set, including -0) clamp to +0.
  assign o_word_c = i_word[DATA_WIDTH-1] ? '0 : i_word;

endmodule

// File: rtl/conv_result_collector.sv
// Serial-to-wide collector at the output of a conv unit PE array.
// Packs H*W result words (raster order) into one feature-map bus and holds it
// until the downstream stage acknowledges it.
// Optional build macro RESULT_RELU_EN: stores negative words as zero (fused ReLU).
module conv_result_collector
  import cnn_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = CNN_DATA_WIDTH,
  parameter  int unsigned H          = 24,
  parameter  int unsigned W          = 24,
  localparam int unsigned N          = H * W,
  localparam int unsigned CW         = $clog2(N + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      in_ready,
  output logic [0:N*DATA_WIDTH-1]   out_map,
  output logic                      out_valid,
  input  logic                      out_ack,
  output logic [CW-1:0]             count,
  output logic                      drop_err
);

  state_e                    r_state;
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic                      r_drop_err;
  logic [CW-1:0]             r_count;
  logic [0:N*DATA_WIDTH-1]   r_map;

  logic [DATA_WIDTH-1:0]     w_store;
  logic                      w_accept;
  logic                      w_last;

`ifdef RESULT_RELU_EN
  relu16 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_relu (
    .i_word   (in_data),
    .o_word_c (w_store)
  );
`else
  assign w_store = in_data;
`endif

  // A word transfers only while collecting; the final slot completes the map.
  assign w_accept = in_valid && (r_state == ST_COLLECT);
  assign w_last   = (r_count == CW'(N - 1));

  // State, word counter and Moore handshake flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_COLLECT;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (in_valid) begin
            r_count <= r_count + CW'(1);
            if (w_last) begin
              r_state     <= ST_FULL;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (out_ack) begin
            r_state     <= ST_COLLECT;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  // Write an accepted word into the slot selected by the counter; old slots persist.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_map <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < int'(N); k++) begin
        if (r_count == CW'(k)) begin
          r_map[DATA_WIDTH*k +: DATA_WIDTH] <= w_store;
        end
      end
    end
  end

  // Sticky flag for any word offered while the collector is not ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_err <= 1'b0;
    end else if (in_valid && (r_state != ST_COLLECT)) begin
      r_drop_err <= 1'b1;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_map   = r_map;
  assign count     = r_count;
  assign drop_err  = r_drop_err;

endmodule

// File: tb/tb_conv_result_collector.sv
// Bench for conv_result_collector: a 2x2 instance for the main sequences and a
// 1x1 instance for the single-word map case. Completed maps are checked by
// monitors against queues of expected maps filled when stimulus is issued.
module tb_conv_result_collector;

  logic        clk = 1'b0;
  logic        reset;

  logic        in_valid0, out_ack0, in_ready0, out_valid0, drop_err0;
  logic [15:0] in_data0;
  logic [0:63] out_map0;
  logic [2:0]  count0;

  logic        in_valid1, out_ack1, in_ready1, out_valid1, drop_err1;
  logic [15:0] in_data1;
  logic [0:15] out_map1;
  logic [0:0]  count1;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] q0[$];
  logic [15:0] q1[$];
  logic [63:0] exp_cur0;
  logic [15:0] exp_cur1;
  logic        prev_v0 = 1'b0;
  logic        prev_v1 = 1'b0;
  logic [63:0] exp5;

  conv_result_collector #(.DATA_WIDTH(16), .H(2), .W(2)) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid0),
    .in_data   (in_data0),
    .in_ready  (in_ready0),
    .out_map   (out_map0),
    .out_valid (out_valid0),
    .out_ack   (out_ack0),
    .count     (count0),
    .drop_err  (drop_err0)
  );

  conv_result_collector #(.DATA_WIDTH(16), .H(1), .W(1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid1),
    .in_data   (in_data1),
    .in_ready  (in_ready1),
    .out_map   (out_map1),
    .out_valid (out_valid1),
    .out_ack   (out_ack1),
    .count     (count1),
    .drop_err  (drop_err1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one word on the 2x2 instance for one edge (in_valid left asserted).
  task automatic send0(input logic [15:0] d);
    in_valid0 = 1'b1;
    in_data0  = d;
    tick();
  endtask

  // Wait (bounded) for a complete map on the 2x2 instance, then acknowledge it.
  task automatic ack0();
    for (int i = 0; i < 20 && !out_valid0; i++) tick();
    chk("ack0_wait_valid", 64'(out_valid0), 64'd1);
    out_ack0 = 1'b1;
    tick();
    out_ack0 = 1'b0;
  endtask

  // Monitor for the 2x2 instance: new map must match the queue head and stay frozen.
  always @(negedge clk) begin
    if (out_valid0 && !prev_v0) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL map0_unexpected: got %h expected none", out_map0);
      end else begin
        exp_cur0 = q0.pop_front();
        chk("map0", out_map0, exp_cur0);
      end
    end else if (out_valid0) begin
      chk("map0_hold", out_map0, exp_cur0);
    end
    prev_v0 = out_valid0;
  end

  // Monitor for the 1x1 instance.
  always @(negedge clk) begin
    if (out_valid1 && !prev_v1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL map1_unexpected: got %h expected none", out_map1);
      end else begin
        exp_cur1 = q1.pop_front();
        chk("map1", 64'(out_map1), 64'(exp_cur1));
      end
    end
    prev_v1 = out_valid1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    in_valid0 = 1'b0; in_data0 = '0; out_ack0 = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ack1 = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // 1: reset state
    chk("rst_in_ready",  64'(in_ready0),  64'd1);
    chk("rst_out_valid", 64'(out_valid0), 64'd0);
    chk("rst_count",     64'(count0),     64'd0);
    chk("rst_out_map",   out_map0,        64'h0);
    chk("rst_drop_err",  64'(drop_err0),  64'd0);

    // 2: four back-to-back words
    q0.push_back(64'h3C00_4000_4200_4400);
    send0(16'h3C00);
    send0(16'h4000);
    chk("t2_map_partial", out_map0, 64'h3C00_4000_0000_0000);
    send0(16'h4200);
    chk("t2_valid_before_last", 64'(out_valid0), 64'd0);
    chk("t2_count3",            64'(count0),     64'd3);
    send0(16'h4400);
    in_valid0 = 1'b0;
    chk("t2_out_valid", 64'(out_valid0), 64'd1);
    chk("t2_in_ready",  64'(in_ready0),  64'd0);
    chk("t2_count_n",   64'(count0),     64'd4);

    // 3: hold without ack while words are offered; then ack together with a word
    in_valid0 = 1'b1;
    in_data0  = 16'hFFFF;
    for (int i = 0; i < 10; i++) tick();
    chk("t3_drop_err",   64'(drop_err0),  64'd1);
    chk("t3_still_full", 64'(out_valid0), 64'd1);
    chk("t3_count_held", 64'(count0),     64'd4);
    out_ack0 = 1'b1;
    tick();
    out_ack0  = 1'b0;
    in_valid0 = 1'b0;
    chk("t3_ack_valid", 64'(out_valid0), 64'd0);
    chk("t3_ack_count", 64'(count0),     64'd0);
    chk("t3_ack_ready", 64'(in_ready0),  64'd1);
    chk("t3_ack_map",   out_map0,        64'h3C00_4000_4200_4400);

    // 4: two words overwrite the old map in place, then a mid-map reset
    send0(16'hAAAA);
    send0(16'hBBBB);
    in_valid0 = 1'b0;
    chk("t4_count2", 64'(count0), 64'd2);
    chk("t4_overwrite", out_map0, 64'hAAAA_BBBB_4200_4400);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_rst_count", 64'(count0),    64'd0);
    chk("t4_rst_map",   out_map0,       64'h0);
    chk("t4_rst_ready", 64'(in_ready0), 64'd1);
    chk("t4_rst_drop",  64'(drop_err0), 64'd0);
    q0.push_back(64'h0001_0002_0003_0004);
    send0(16'h0001);
    send0(16'h0002);
    send0(16'h0003);
    send0(16'h0004);
    in_valid0 = 1'b0;
    ack0();

    // 5: negative words, stored bit-exact or clamped depending on build
`ifdef RESULT_RELU_EN
    exp5 = 64'h0000_3C00_0000_0000;
`else
    exp5 = 64'hBC00_3C00_8001_0000;
`endif
    q0.push_back(exp5);
    send0(16'hBC00);
    send0(16'h3C00);
    send0(16'h8001);
    send0(16'h0000);
    in_valid0 = 1'b0;
    chk("t5_map", out_map0, exp5);
    ack0();
    chk("t5_drop_err", 64'(drop_err0), 64'd0);

    // 6: N=1, gapped input, ack on the cycle out_valid rises
    for (int m = 0; m < 3; m++) begin
      logic [15:0] d;
      d = (m == 0) ? 16'h1234 : (m == 1) ? 16'h5678 : 16'h7ABC;
      q1.push_back(d);
      in_valid1 = 1'b1;
      in_data1  = d;
      tick();
      in_valid1 = 1'b0;
      chk("t6_valid", 64'(out_valid1), 64'd1);
      chk("t6_count", 64'(count1),     64'd1);
      out_ack1 = 1'b1;
      tick();
      out_ack1 = 1'b0;
      chk("t6_ready_after_ack", 64'(in_ready1), 64'd1);
      tick();
    end
    chk("t6_drop_err", 64'(drop_err1), 64'd0);

    tick(); tick();
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
